// File: rtl/icb_pkg.sv
// icb_pkg: shared state type and AXI burst constants for the I-cache line bridge
package icb_pkg;
  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_e;
  localparam int LINE_BITS = 256;
  localparam logic [7:0] BURST_LEN = 8'd7;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
endpackage

// File: rtl/i_line_asm.sv
// i_line_asm: line buffer written by beat index, with a saturating beat counter
module i_line_asm #(
  parameter int WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [31:0]           wdata_i,
  output logic [32*WORDS-1:0]   line_o
);
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  logic [WORDS-1:0][31:0] line_q;
  logic [CW-1:0] cnt_q;
  // store each beat in slot cnt_q; the counter sticks at the last word so overrun beats overwrite it
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (we_i) begin
      line_q[cnt_q] <= wdata_i;
      cnt_q <= (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    end
  end
  assign line_o = line_q;
endmodule

// File: rtl/i_line_axi_bridge.sv
// i_line_axi_bridge: sram-like line read to one 8-beat AXI INCR burst; ICB_PERF_CNT_EN adds perf counters
module i_line_axi_bridge
  import icb_pkg::*;
#(
  parameter int                ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID   = '0,
  parameter int                LINE_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 wr,
  input  logic [1:0]           size,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [LINE_BITS-1:0] rdata,
  output logic                 addr_ok,
  output logic                 data_ok,
  output logic [ID_WIDTH-1:0]  arid,
  output logic [31:0]          araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic [1:0]           arlock,
  output logic [3:0]           arcache,
  output logic [2:0]           arprot,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [ID_WIDTH-1:0]  rid,
  input  logic [31:0]          rdata_axi,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready
`ifdef ICB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_line_cnt,
  output logic [31:0]          perf_busy_cnt
`endif
);
  state_e state_q;
  logic arvalid_q, rready_q, data_ok_q;
  logic [31:0] araddr_q;
  logic start, beat_we;
  logic unused_inputs;
  assign unused_inputs = ^{wr, size, wdata, rid, rresp, addr[4:0]};
  assign start   = (state_q == IDLE) && req;
  assign beat_we = (state_q == R) && rvalid;
  assign addr_ok = arvalid_q & arready;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign data_ok = data_ok_q;
  assign araddr  = araddr_q;
  assign arid    = AXI_ID;
  assign arlen   = BURST_LEN;
  assign arsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  // request/burst sequencer with registered handshake outputs; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      araddr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          state_q   <= AR;
          arvalid_q <= 1'b1;
          araddr_q  <= {addr[31:5], 5'b0};
        end
        AR: if (arready) begin
          state_q   <= R;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
        end
        R: if (rvalid && rlast) begin
          state_q   <= DONE;
          rready_q  <= 1'b0;
          data_ok_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          data_ok_q <= 1'b0;
        end
      endcase
    end
  end
  i_line_asm #(.WORDS(LINE_WORDS)) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start),
    .we_i    (beat_we),
    .wdata_i (rdata_axi),
    .line_o  (rdata)
  );
`ifdef ICB_PERF_CNT_EN
  // free-running wrap-around counters of completed lines and non-idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_line_cnt <= '0;
      perf_busy_cnt <= '0;
    end else begin
      perf_line_cnt <= perf_line_cnt + {31'd0, data_ok_q};
      perf_busy_cnt <= perf_busy_cnt + {31'd0, state_q != IDLE};
    end
  end
`endif
endmodule

// File: tb/tb_i_line_axi_bridge.sv
// tb_i_line_axi_bridge: randomized scoreboard bench for the I-cache line bridge
module tb_i_line_axi_bridge;
  logic clk = 0, rst = 1, req = 0, wr = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [255:0] rdata;
  logic addr_ok, data_ok;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid, arready = 0;
  logic [3:0] rid = 0;
  logic [31:0] rdata_axi = 0;
  logic [1:0] rresp = 0;
  logic rlast = 0, rvalid = 0, rready;
`ifdef ICB_PERF_CNT_EN
  logic [31:0] perf_line_cnt, perf_busy_cnt;
`endif

  i_line_axi_bridge dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata_axi(rdata_axi),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef ICB_PERF_CNT_EN
    , .perf_line_cnt(perf_line_cnt), .perf_busy_cnt(perf_busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int ar_starts = 0, closed = 0, aborts = 0, rlast_cyc = -10, dok_cyc = -1, aok_cyc = -1, req_cyc = 0;
  int perf_lines = 0, perf_busy = 0;
  logic prev_dok = 0, prev_arv = 0;
  logic [7:0][31:0] model = '0;
  logic [255:0] exp_line_q[$];
  logic [31:0] exp_addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: checks AR channel, pulses and lines against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      check("addr_ok", addr_ok, arvalid & arready);
      if (addr_ok) aok_cyc = cyc;
      if (arvalid) begin
        if (!prev_arv) begin
          check("ar_after_done", closed, ar_starts);
          ar_starts++;
        end
        if (exp_addr_q.size() == 0) check("araddr_unexpected", 1, 0);
        else check("araddr", araddr, exp_addr_q[0]);
        check("ar_fixed", {arid, arlen, arsize, arburst, arlock, arcache, arprot},
              {4'd0, 8'd7, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
        if (arready && exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
      end
      if (rvalid && rready && rlast) rlast_cyc = cyc;
      if (arvalid | rready | data_ok) perf_busy++;
      if (data_ok) begin
        dok_cyc = cyc;
        check("dok_pulse", prev_dok, 0);
        check("dok_after_rlast", cyc, rlast_cyc + 1);
        if (exp_line_q.size() == 0) check("dok_unexpected", 1, 0);
        else check("rdata", rdata, exp_line_q.pop_front());
        closed++;
        perf_lines++;
      end
      prev_dok = data_ok;
      prev_arv = arvalid;
    end
  end

  // driver + AXI slave; abort_at >= 0 pulses rst instead of sending that beat
  task automatic do_req(input logic [31:0] a, input int ard, input int gmin, input int gmax,
                        input int nb, input int abort_at, input bit seq);
    logic [7:0][31:0] line;
    logic [31:0] d[$];
    int n;
    line = model;
    for (int k = 0; k < nb; k++) begin
      d.push_back(seq ? 32'h1000 + k : $urandom);
      line[k < 7 ? k : 7] = d[k];
    end
    exp_addr_q.push_back({a[31:5], 5'b0});
    if (abort_at < 0) begin
      exp_line_q.push_back(line);
      model = line;
    end
    req = 1; addr = a; wr = 1'($urandom); size = 2'($urandom); wdata = $urandom;
    req_cyc = cyc;
    n = 0;
    while (!arvalid && n < 100) begin @(posedge clk); #1; n++; end
    if (!arvalid) check("ar_timeout", 0, 1);
    repeat (ard) begin
      @(posedge clk); #1;
      check("arvalid_hold", arvalid, 1);
    end
    arready = 1;
    @(posedge clk); #1;
    arready = 0; req = 0;
    for (int k = 0; k < nb; k++) begin
      if (k == abort_at) begin
        rvalid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_data_ok", data_ok, 0);
        check("rst_rdata", rdata, 0);
        model = '0; aborts++; closed++; perf_lines = 0; perf_busy = 0;
        return;
      end
      repeat ($urandom_range(gmax, gmin)) begin rvalid = 0; @(posedge clk); #1; end
      rvalid = 1; rdata_axi = d[k]; rlast = (k == nb - 1);
      rid = 4'($urandom); rresp = 2'($urandom);
      @(posedge clk); #1;
    end
    rvalid = 0; rlast = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("reset_outs", {arvalid, rready, addr_ok, data_ok}, 4'b0);
    check("reset_araddr", araddr, 0);
    check("reset_rdata", rdata, 0);
    do_req(32'hBFC00014, 0, 0, 0, 8, -1, 1);
    repeat (2) @(posedge clk); #1;
    check("lat_addr_ok", aok_cyc - req_cyc, 1);
    check("lat_data_ok", dok_cyc - req_cyc, 10);
    do_req($urandom, 3, 0, 0, 8, -1, 0);
    do_req($urandom, 0, 1, 1, 8, -1, 0);
    do_req(32'h00000020, 0, 0, 0, 8, -1, 0);
    do_req(32'h00000040, 0, 0, 0, 8, -1, 0);
    repeat (2) @(posedge clk); #1;
    do_req($urandom, 1, 0, 0, 8, 4, 0);
    do_req($urandom, 0, 0, 1, 7, -1, 0);
    do_req($urandom, 0, 0, 0, 7, -1, 0);
    do_req($urandom, 0, 0, 1, 10, -1, 0);
    for (int i = 0; i < 40; i++)
      do_req($urandom, $urandom_range(0, 3), 0, $urandom_range(0, 2),
             ($urandom_range(0, 9) < 7) ? 8 : $urandom_range(5, 10), -1, 0);
    repeat (4) @(posedge clk); #1;
    check("sb_lines_left", exp_line_q.size(), 0);
    check("sb_addrs_left", exp_addr_q.size(), 0);
`ifdef ICB_PERF_CNT_EN
    check("perf_line_cnt", perf_line_cnt, perf_lines);
    check("perf_busy_cnt", perf_busy_cnt, perf_busy);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
